// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared widths, request record and arbiter state for the DRAM request arbiter
package dram_pkg;

    localparam int DRAM_LANE_W      = 128;
    localparam int DRAM_HALF_ADDR_W = 11;
    localparam int DRAM_LINE_ADDR_W = 22;

    typedef struct packed {
        logic [DRAM_LINE_ADDR_W-1:0] addr_read;
        logic [DRAM_HALF_ADDR_W-1:0] addr_write_up;
        logic                        dirty;
        logic [DRAM_LANE_W-1:0]      lane_wr;
    } line_req_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT_ACK
    } arb_state_e;

    // Watchdog counter is never narrower than 8 bits
    function automatic int wd_width(input int timeout);
        return ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request scanning up from ptr+1
module rr_pick #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    function automatic logic [W-1:0] wrap(input int v);
        return W'(v % N);
    endfunction

    // Scan from the far end down so the nearest candidate after ptr is written last
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[wrap(int'(ptr_i) + k)]) begin
                found_o = 1'b1;
                idx_o   = wrap(int'(ptr_i) + k);
            end
        end
    end

endmodule

// File: rtl/dram_request_arbiter.sv
// rtl/dram_request_arbiter.sv - round-robin share of the DRAM line port with registered fields and watchdog
module dram_request_arbiter
    import dram_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   main_clk,
    input  logic                                   main_rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*DRAM_LINE_ADDR_W-1:0]    req_addr_read,
    input  logic [NUM_REQ*DRAM_HALF_ADDR_W-1:0]    req_addr_write_up,
    input  logic [NUM_REQ-1:0]                     req_dirty,
    input  logic [NUM_REQ*DRAM_LANE_W-1:0]         req_lane_wr,
    output logic [NUM_REQ-1:0]                     req_ack,
    output logic [DRAM_LANE_W-1:0]                 rsp_lane,
    output logic [DRAM_HALF_ADDR_W-1:0]            dram_addr_read_up,
    output logic [DRAM_HALF_ADDR_W-1:0]            dram_addr_write_up,
    output logic [DRAM_HALF_ADDR_W-1:0]            dram_addr_common,
    output logic [DRAM_LANE_W-1:0]                 dram_lane_wr,
    output logic                                   dram_dirty,
    output logic                                   dram_req_pulse,
    input  logic                                   dram_ack_pulse,
    input  logic [DRAM_LANE_W-1:0]                 dram_lane_rd,
    output logic                                   timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = wd_width(TIMEOUT_CYCLES);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           grant_q, grant_d;
    line_req_t               fields_q, fields_d;
    logic                    pulse_q, pulse_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [DRAM_LANE_W-1:0]  rsp_q, rsp_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    tout_q, tout_d;

    line_req_t               cand [NUM_REQ];
    logic                    pick_found;
    logic [IW-1:0]           pick_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
        assign cand[g] = {req_addr_read[g*DRAM_LINE_ADDR_W +: DRAM_LINE_ADDR_W],
                          req_addr_write_up[g*DRAM_HALF_ADDR_W +: DRAM_HALF_ADDR_W],
                          req_dirty[g],
                          req_lane_wr[g*DRAM_LANE_W +: DRAM_LANE_W]};
    end

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) state_q <= ARB_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:     if (pick_found)     state_d = ARB_WAIT_ACK;
            ARB_WAIT_ACK: if (dram_ack_pulse) state_d = ARB_IDLE;
            default:                          state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        fields_d = fields_q;
        pulse_d  = 1'b0;
        ack_d    = '0;
        rsp_d    = rsp_q;
        cnt_d    = cnt_q;
        tout_d   = tout_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    ptr_d    = pick_idx;
                    grant_d  = pick_idx;
                    fields_d = cand[pick_idx];
                    pulse_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            ARB_WAIT_ACK: begin
                // Saturate rather than wrap; the FSM keeps waiting after a timeout
                if (cnt_q != CW'(TIMEOUT_CYCLES)) cnt_d = cnt_q + 1'b1;
                if (cnt_d == CW'(TIMEOUT_CYCLES)) tout_d = 1'b1;
                if (dram_ack_pulse) begin
                    rsp_d          = dram_lane_rd;
                    ack_d[grant_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            ptr_q    <= IW'(NUM_REQ - 1);
            grant_q  <= '0;
            fields_q <= '0;
            pulse_q  <= 1'b0;
            ack_q    <= '0;
            rsp_q    <= '0;
            cnt_q    <= '0;
            tout_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            fields_q <= fields_d;
            pulse_q  <= pulse_d;
            ack_q    <= ack_d;
            rsp_q    <= rsp_d;
            cnt_q    <= cnt_d;
            tout_q   <= tout_d;
        end
    end

    assign req_ack            = ack_q;
    assign rsp_lane           = rsp_q;
    assign dram_addr_read_up  = fields_q.addr_read[DRAM_LINE_ADDR_W-1:DRAM_HALF_ADDR_W];
    assign dram_addr_common   = fields_q.addr_read[DRAM_HALF_ADDR_W-1:0];
    assign dram_addr_write_up = fields_q.addr_write_up;
    assign dram_lane_wr       = fields_q.lane_wr;
    assign dram_dirty         = fields_q.dirty;
    assign dram_req_pulse     = pulse_q;
    assign timeout_err        = tout_q;

endmodule

// File: tb/tb_dram_request_arbiter.sv
// tb/tb_dram_request_arbiter.sv - directed self-checking bench for dram_request_arbiter
module tb_dram_request_arbiter;

    localparam int NR = 2;

    logic            main_clk = 1'b0;
    logic            main_rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*22-1:0]  req_addr_read;
    logic [NR*11-1:0]  req_addr_write_up;
    logic [NR-1:0]   req_dirty;
    logic [NR*128-1:0] req_lane_wr;
    logic [NR-1:0]   req_ack;
    logic [127:0]    rsp_lane;
    logic [10:0]     dram_addr_read_up, dram_addr_write_up, dram_addr_common;
    logic [127:0]    dram_lane_wr;
    logic            dram_dirty, dram_req_pulse, dram_ack_pulse, timeout_err;
    logic [127:0]    dram_lane_rd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_pulse;
    logic [NR-1:0] exp_grant;

    dram_request_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(8)) dut (
        .main_clk           (main_clk),
        .main_rst_n         (main_rst_n),
        .req_valid          (req_valid),
        .req_addr_read      (req_addr_read),
        .req_addr_write_up  (req_addr_write_up),
        .req_dirty          (req_dirty),
        .req_lane_wr        (req_lane_wr),
        .req_ack            (req_ack),
        .rsp_lane           (rsp_lane),
        .dram_addr_read_up  (dram_addr_read_up),
        .dram_addr_write_up (dram_addr_write_up),
        .dram_addr_common   (dram_addr_common),
        .dram_lane_wr       (dram_lane_wr),
        .dram_dirty         (dram_dirty),
        .dram_req_pulse     (dram_req_pulse),
        .dram_ack_pulse     (dram_ack_pulse),
        .dram_lane_rd       (dram_lane_rd),
        .timeout_err        (timeout_err)
    );

    always #5 main_clk = ~main_clk;
    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic wait_pulse(input string tag);
        int waited = 0;
        while (!dram_req_pulse && waited < 20) begin
            tick();
            waited++;
        end
        check(tag, dram_req_pulse, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},   req_ack, '0);
        check({tag, "_rsp"},   rsp_lane, '0);
        check({tag, "_pulse"}, dram_req_pulse, 1'b0);
        check({tag, "_flds"},  {dram_addr_read_up, dram_addr_write_up, dram_addr_common, dram_dirty}, '0);
        check({tag, "_lane"},  dram_lane_wr, '0);
        check({tag, "_tout"},  timeout_err, 1'b0);
    endtask

    initial begin
        main_rst_n = 1'b0;
        req_valid = '0; req_addr_read = '0; req_addr_write_up = '0;
        req_dirty = '0; req_lane_wr = '0;
        dram_ack_pulse = 1'b0; dram_lane_rd = '0;
        tick(); tick();
        check_idle_outputs("reset");

        // Single request from requester 0, prefetch-hit timing
        main_rst_n = 1'b1;
        req_valid = 2'b01;
        req_addr_read[21:0] = 22'h12345;
        req_lane_wr[127:0]  = 128'h1111;
        tick();
        check("t1_pulse", dram_req_pulse, 1'b1);
        check("t1_read_up", dram_addr_read_up, 11'h024);
        check("t1_common", dram_addr_common, 11'h345);
        check("t1_dirty", dram_dirty, 1'b0);
        tick();
        check("t1_pulse_one_cycle", dram_req_pulse, 1'b0);
        dram_ack_pulse = 1'b1;
        dram_lane_rd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        tick();
        check("t1_ack", req_ack, 2'b01);
        check("t1_rsp", rsp_lane, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        dram_ack_pulse = 1'b0; dram_lane_rd = '0; req_valid = '0;
        tick();
        check("t1_ack_gone", req_ack, 2'b00);
        check("t1_rsp_held", rsp_lane, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        check("t1_no_repulse", dram_req_pulse, 1'b0);

        // Both held: last winner was 0, so grants go 1,0,1,0
        req_addr_read[21:0]  = 22'h000001;
        req_addr_read[43:22] = 22'h000002;
        req_valid = 2'b11;
        last_pulse = -100;
        exp_grant = 2'b10;
        for (int g = 0; g < 4; g++) begin
            wait_pulse("t2_pulse_seen");
            check("t2_pulse_gap", (cyc - last_pulse) >= 2, 1'b1);
            last_pulse = cyc;
            check("t2_grant_addr", dram_addr_common, exp_grant[1] ? 11'h002 : 11'h001);
            for (int w = 0; w < 3; w++) begin
                tick();
                check("t2_no_extra_pulse", dram_req_pulse, 1'b0);
            end
            dram_ack_pulse = 1'b1;
            dram_lane_rd = 128'(g + 16'h100);
            tick();
            dram_ack_pulse = 1'b0;
            check("t2_ack", req_ack, exp_grant);
            check("t2_rsp", rsp_lane, 128'(g + 16'h100));
            if (g == 3) req_valid = '0;
            exp_grant = ~exp_grant;
        end
        tick(); tick();
        check("t2_quiet", dram_req_pulse, 1'b0);

        // Dirty write-back fields must stay latched while inputs change
        req_valid = 2'b01;
        req_dirty[0] = 1'b1;
        req_addr_write_up[10:0] = 11'h7FF;
        req_addr_read[21:0] = 22'h3ABCD;
        req_lane_wr[127:0] = {16{8'hA5}};
        wait_pulse("t3_pulse_seen");
        req_dirty = '0; req_addr_write_up = '0; req_addr_read = '0; req_lane_wr = '0;
        for (int w = 0; w < 4; w++) begin
            check("t3_dirty", dram_dirty, 1'b1);
            check("t3_write_up", dram_addr_write_up, 11'h7FF);
            check("t3_read_up", dram_addr_read_up, 11'h075);
            check("t3_common", dram_addr_common, 11'h3CD);
            check("t3_lane", dram_lane_wr, {16{8'hA5}});
            if (w == 3) dram_ack_pulse = 1'b1;
            tick();
        end
        dram_ack_pulse = 1'b0;
        check("t3_ack", req_ack, 2'b01);
        req_valid = '0;
        tick();
        check("t3_held_in_idle", {dram_dirty, dram_addr_write_up}, {1'b1, 11'h7FF});

        // Watchdog: requester 1, ack withheld
        req_valid = 2'b10;
        wait_pulse("t4_pulse_seen");
        for (int w = 0; w < 7; w++) tick();
        check("t4_tout_before", timeout_err, 1'b0);
        tick();
        check("t4_tout_after", timeout_err, 1'b1);
        tick(); tick();
        dram_ack_pulse = 1'b1;
        tick();
        dram_ack_pulse = 1'b0;
        check("t4_late_ack", req_ack, 2'b10);
        req_valid = '0;
        tick();
        check("t4_tout_sticky", timeout_err, 1'b1);

        // Requester 1 drops req_valid mid-transaction
        req_valid = 2'b10;
        wait_pulse("t6_pulse_seen");
        req_valid = '0;
        tick(); tick();
        check("t6_no_repulse", dram_req_pulse, 1'b0);
        dram_ack_pulse = 1'b1;
        dram_lane_rd = 128'h66;
        tick();
        dram_ack_pulse = 1'b0;
        check("t6_ack", req_ack, 2'b10);
        check("t6_rsp", rsp_lane, 128'h66);
        for (int w = 0; w < 3; w++) begin
            tick();
            check("t6_quiet", dram_req_pulse, 1'b0);
        end

        // Reset mid-WAIT_ACK, then a stray ack
        req_valid = 2'b01;
        req_addr_read[21:0] = 22'h0ABCD;
        wait_pulse("t5_pulse_seen");
        tick();
        main_rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        req_valid = '0;
        tick();
        main_rst_n = 1'b1;
        dram_ack_pulse = 1'b1;
        dram_lane_rd = 128'h55;
        tick();
        dram_ack_pulse = 1'b0;
        check_idle_outputs("t5_stray");
        // Back in IDLE with pointer reset: requester 0 wins a tie
        req_valid = 2'b11;
        req_addr_read[21:0]  = 22'h000011;
        req_addr_read[43:22] = 22'h000022;
        tick();
        check("t5_regrant_pulse", dram_req_pulse, 1'b1);
        check("t5_regrant_winner", dram_addr_common, 11'h011);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
